// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bit positions for the pipelined ALU.
package alu_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t ADD     = 4'd0;
    localparam opcode_t NEGA    = 4'd1;
    localparam opcode_t AND     = 4'd2;
    localparam opcode_t OR      = 4'd3;
    localparam opcode_t XOR     = 4'd4;
    localparam opcode_t INVA    = 4'd5;
    localparam opcode_t SELAB   = 4'd6;
    localparam opcode_t SELBA   = 4'd7;
    localparam opcode_t SUB     = 4'd8;
    localparam opcode_t ALTB    = 4'd9;
    localparam opcode_t ALTEB   = 4'd10;
    localparam opcode_t AGTB    = 4'd11;
    localparam opcode_t AGTEB   = 4'd12;
    localparam opcode_t AEQB    = 4'd13;
    localparam opcode_t ANEQB   = 4'd14;
    localparam opcode_t SELXORB = 4'd15;

    // Bit positions inside the 4-bit {C, V, N, ZF} status word.
    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result bus of the pipelined ALU: input beat handshake plus result handshake.
interface alu_pipe_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    opcode_t          inst;
    logic             sel;
    logic             acc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] z;
    logic [3:0]       flags;

    // Issue/write-back side: drives operands and consumes results.
    modport master (
        output in_valid, a, b, inst, sel, acc, out_ready,
        input  in_ready, out_valid, z, flags
    );

    // ALU side.
    modport slave (
        input  in_valid, a, b, inst, sel, acc, out_ready,
        output in_ready, out_valid, z, flags
    );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and {C, V, N, ZF} from effective operands.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit SIGNED_CMP = 1'b1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  opcode_t          inst,
    input  logic             sel,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] neg;
    logic             lt;
    logic             eq;
    logic             cmp_bit;
    logic             carry;
    logic             ovf;

    // Shared adder, subtractor (carry-out = no-borrow), negation and comparators.
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        neg  = ~a + {{(WIDTH-1){1'b0}}, 1'b1};
        eq   = (a == b);
        if (SIGNED_CMP) begin
            lt = ($signed(a) < $signed(b));
        end else begin
            lt = (a < b);
        end
    end

    // Opcode select; compare opcodes yield a single bit zero-extended to the datapath.
    always_comb begin
        result  = '0;
        cmp_bit = 1'b0;
        carry   = 1'b0;
        ovf     = 1'b0;
        case (inst)
            ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
                ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            NEGA: begin
                result = neg;
                ovf    = a[WIDTH-1] && neg[WIDTH-1];
            end
            AND:     result = a & b;
            OR:      result = a | b;
            XOR:     result = a ^ b;
            INVA:    result = ~a;
            SELAB:   result = sel ? b : a;
            SELBA:   result = sel ? a : b;
            SUB: begin
                result = diff[WIDTH-1:0];
                carry  = diff[WIDTH];
                ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALTB:    cmp_bit = lt;
            ALTEB:   cmp_bit = lt || eq;
            AGTB:    cmp_bit = !(lt || eq);
            AGTEB:   cmp_bit = !lt;
            AEQB:    cmp_bit = eq;
            ANEQB:   cmp_bit = !eq;
            SELXORB: cmp_bit = sel ^ b[0];
            default: result  = '0;
        endcase
        if (inst >= ALTB) begin
            result = {{(WIDTH-1){1'b0}}, cmp_bit};
        end
    end

    // Status word assembled from the selected result.
    always_comb begin
        flags         = '0;
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
        flags[FLAG_N] = result[WIDTH-1];
        flags[FLAG_Z] = (result == '0);
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: S1 holds the accepted beat, S2 holds the registered result.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit SIGNED_CMP = 1'b1
) (
    input logic       clk,
    input logic       rst_n,
    alu_pipe_if.slave bus
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q,     s1_a_d;
    logic [WIDTH-1:0] s1_b_q,     s1_b_d;
    opcode_t          s1_inst_q,  s1_inst_d;
    logic             s1_sel_q,   s1_sel_d;
    logic             s1_acc_q,   s1_acc_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] z_q,        z_d;
    logic [3:0]       flags_q,    flags_d;
    logic [WIDTH-1:0] acc_q,      acc_d;

    logic             s2_adv;
    logic             in_ready;
    logic [WIDTH-1:0] eff_a;
    logic [WIDTH-1:0] core_result;
    logic [3:0]       core_flags;

    // Accumulate beats take the most recent result instead of their own A operand.
    always_comb begin
        eff_a = s1_acc_q ? acc_q : s1_a_q;
    end

    alu_core #(
        .WIDTH      (WIDTH),
        .SIGNED_CMP (SIGNED_CMP)
    ) u_core (
        .a      (eff_a),
        .b      (s1_b_q),
        .inst   (s1_inst_q),
        .sel    (s1_sel_q),
        .result (core_result),
        .flags  (core_flags)
    );

    // Handshake and next-state: S2 moves when empty or drained, S1 refills in the same cycle.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_inst_d  = s1_inst_q;
        s1_sel_d   = s1_sel_q;
        s1_acc_d   = s1_acc_q;
        s2_valid_d = s2_valid_q;
        z_d        = z_q;
        flags_d    = flags_q;
        acc_d      = acc_q;

        s2_adv   = !s2_valid_q || bus.out_ready;
        in_ready = !s1_valid_q || s2_adv;

        if (in_ready) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_a_d    = bus.a;
                s1_b_d    = bus.b;
                s1_inst_d = bus.inst;
                s1_sel_d  = bus.sel;
                s1_acc_d  = bus.acc;
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                z_d     = core_result;
                flags_d = core_flags;
                acc_d   = core_result;
            end
        end
    end

    // Pipeline, result and accumulator registers; reset drops every in-flight beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_inst_q  <= ADD;
            s1_sel_q   <= 1'b0;
            s1_acc_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            z_q        <= '0;
            flags_q    <= '0;
            acc_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_inst_q  <= s1_inst_d;
            s1_sel_q   <= s1_sel_d;
            s1_acc_q   <= s1_acc_d;
            s2_valid_q <= s2_valid_d;
            z_q        <= z_d;
            flags_q    <= flags_d;
            acc_q      <= acc_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.z         = z_q;
    assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: random ops against an arithmetic reference model,
// directed flag/signedness/accumulate cases, back-pressure and mid-stream reset.
module tb_alu_pipe;
    import alu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(32)) bus   ();
    alu_pipe_if #(.WIDTH(32)) bus_u ();
    alu_pipe_if #(.WIDTH(8))  bus8  ();

    alu_pipe #(.WIDTH(32), .SIGNED_CMP(1'b1)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
    alu_pipe #(.WIDTH(32), .SIGNED_CMP(1'b0)) dut_u (.clk(clk), .rst_n(rst_n), .bus(bus_u));
    alu_pipe #(.WIDTH(8),  .SIGNED_CMP(1'b1)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

    int total = 0;
    int bad   = 0;
    int cycle_cnt = 0;
    int accepted  = 0;
    int accept_cycle = 0;

    logic [31:0] model_acc;
    logic [31:0] exp_z_q[$];
    logic [3:0]  exp_f_q[$];

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Reference ALU on plain integers: w-bit modulo arithmetic, signed values as longint.
    function automatic void ref_alu(input int w, input bit scmp,
                                    input logic [63:0] a_in, input logic [63:0] b_in,
                                    input logic [3:0] op, input logic sel,
                                    output logic [63:0] z, output logic [3:0] f);
        logic [63:0] mask, a, b;
        longint sa, sb, smax, smin, r;
        bit c, v, lt, eq;
        mask = (64'd1 << w) - 64'd1;
        a = a_in & mask;
        b = b_in & mask;
        smax = (longint'(1) <<< (w - 1)) - 1;
        smin = -(longint'(1) <<< (w - 1));
        sa = a[w-1] ? longint'(a) - (longint'(1) <<< w) : longint'(a);
        sb = b[w-1] ? longint'(b) - (longint'(1) <<< w) : longint'(b);
        lt = scmp ? (sa < sb) : (a < b);
        eq = (a == b);
        c = 0; v = 0; z = 0;
        case (op)
            4'd0:  begin z = a + b; c = z[w]; r = sa + sb; v = (r > smax) || (r < smin); end
            4'd1:  begin z = 64'd0 - a; r = -sa; v = (r > smax); end
            4'd2:  z = a & b;
            4'd3:  z = a | b;
            4'd4:  z = a ^ b;
            4'd5:  z = ~a;
            4'd6:  z = sel ? b : a;
            4'd7:  z = sel ? a : b;
            4'd8:  begin z = a - b; c = (a >= b); r = sa - sb; v = (r > smax) || (r < smin); end
            4'd9:  z = 64'(lt);
            4'd10: z = 64'(lt || eq);
            4'd11: z = 64'(!(lt || eq));
            4'd12: z = 64'(!lt);
            4'd13: z = 64'(eq);
            4'd14: z = 64'(!eq);
            default: z = 64'(sel ^ b[0]);
        endcase
        z = z & mask;
        f = {c, v, z[w-1], (z == 64'd0)};
    endfunction

    // Present one beat on the main bus from a negedge and hold it until accepted.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input logic sel, input logic acc);
        logic [63:0] ez;
        logic [3:0]  ef;
        logic [31:0] ea;
        logic        ok;
        ok = 1'b0;
        bus.a = a; bus.b = b; bus.inst = op; bus.sel = sel; bus.acc = acc;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 40 && !ok; k++) begin
            #1;
            ok = bus.in_ready;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.acc = 1'b0;
        if (!ok) begin
            total++; bad++;
            $display("[TB] FAIL issue_timeout: in_ready=0, required 1 within 40 cycles");
        end else begin
            accepted++;
            accept_cycle = cycle_cnt;
            ea = acc ? model_acc : a;
            ref_alu(32, 1'b1, {32'd0, ea}, {32'd0, b}, op, sel, ez, ef);
            exp_z_q.push_back(ez[31:0]);
            exp_f_q.push_back(ef);
            model_acc = ez[31:0];
        end
    endtask

    // Wait (bounded) for a result transfer on the main bus and capture it.
    task automatic collect(input int bound, output logic [31:0] z, output logic [3:0] f,
                           output logic got, output int when);
        got = 1'b0; z = '0; f = '0; when = 0;
        for (int k = 0; k < bound && !got; k++) begin
            #1;
            if (bus.out_valid && bus.out_ready) begin
                got = 1'b1; z = bus.z; f = bus.flags; when = cycle_cnt;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b, want 0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b, want 1", bus.in_ready); end
        total++; if (bus.z !== 32'd0) begin bad++; $display("[TB] FAIL reset_z: got %h, want 0", bus.z); end
        total++; if (bus.flags !== 4'd0) begin bad++; $display("[TB] FAIL reset_flags: got %b, want 0000", bus.flags); end
        model_acc = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random_ops();
        logic [31:0] z, ez;
        logic [3:0]  f, ef;
        logic        got;
        int          when;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 48; i++) begin
            issue($urandom, $urandom, 4'(i % 16), 1'($urandom_range(0, 1)), (i % 5) == 4);
            collect(3, z, f, got, when);
            total++;
            if (!got || exp_z_q.size() == 0) begin
                bad++; $display("[TB] FAIL rand_latency[%0d]: out_valid=%b, required 1 within 3 cycles", i, got);
            end else begin
                ez = exp_z_q.pop_front();
                ef = exp_f_q.pop_front();
                total++; if (z !== ez) begin bad++; $display("[TB] FAIL rand_z[%0d] op=%0d: got %h, want %h", i, i % 16, z, ez); end
                total++; if (f !== ef) begin bad++; $display("[TB] FAIL rand_flags[%0d] op=%0d: got %b, want %b", i, i % 16, f, ef); end
                total++; if ($isunknown(z)) begin bad++; $display("[TB] FAIL rand_xz[%0d]: got %h, want no X/Z", i, z); end
            end
        end
    endtask

    task automatic test_flags();
        logic [31:0] z;
        logic [3:0]  f;
        logic        got;
        int          when;
        bus.out_ready = 1'b1;
        issue(32'h7FFF_FFFF, 32'd1, ADD, 1'b0, 1'b0);
        collect(3, z, f, got, when);
        void'(exp_z_q.pop_front()); void'(exp_f_q.pop_front());
        total++; if (!got || z !== 32'h8000_0000) begin bad++; $display("[TB] FAIL add_ovf_z: got %h, want 80000000", z); end
        total++; if (f !== 4'b0110) begin bad++; $display("[TB] FAIL add_ovf_flags: got %b, want 0110", f); end
        issue(32'd5, 32'd5, SUB, 1'b0, 1'b0);
        collect(3, z, f, got, when);
        void'(exp_z_q.pop_front()); void'(exp_f_q.pop_front());
        total++; if (!got || z !== 32'd0) begin bad++; $display("[TB] FAIL sub_eq_z: got %h, want 0", z); end
        total++; if (f !== 4'b1001) begin bad++; $display("[TB] FAIL sub_eq_flags: got %b, want 1001", f); end
    endtask

    task automatic test_signedness();
        logic [31:0] z, zu;
        logic [7:0]  z8;
        logic [3:0]  f, f8;
        logic        got;
        int          when;
        bus.out_ready = 1'b1;
        issue(32'hFFFF_FFFF, 32'd1, ALTB, 1'b0, 1'b0);
        collect(3, z, f, got, when);
        void'(exp_z_q.pop_front()); void'(exp_f_q.pop_front());
        total++; if (!got || z !== 32'd1) begin bad++; $display("[TB] FAIL altb_signed: got %h, want 1", z); end

        bus_u.a = 32'hFFFF_FFFF; bus_u.b = 32'd1; bus_u.inst = ALTB; bus_u.sel = 1'b0;
        bus_u.acc = 1'b0; bus_u.out_ready = 1'b1; bus_u.in_valid = 1'b1;
        @(negedge clk);
        bus_u.in_valid = 1'b0;
        got = 1'b0; zu = 32'hDEAD_BEEF;
        for (int k = 0; k < 4 && !got; k++) begin
            #1;
            if (bus_u.out_valid) begin got = 1'b1; zu = bus_u.z; end
            @(negedge clk);
        end
        total++; if (!got || zu !== 32'd0) begin bad++; $display("[TB] FAIL altb_unsigned: got %h valid=%b, want 0", zu, got); end

        bus8.a = 8'h80; bus8.b = 8'h00; bus8.inst = NEGA; bus8.sel = 1'b0;
        bus8.acc = 1'b0; bus8.out_ready = 1'b1; bus8.in_valid = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        got = 1'b0; z8 = 8'h00; f8 = 4'h0;
        for (int k = 0; k < 4 && !got; k++) begin
            #1;
            if (bus8.out_valid) begin got = 1'b1; z8 = bus8.z; f8 = bus8.flags; end
            @(negedge clk);
        end
        total++; if (!got || z8 !== 8'h80) begin bad++; $display("[TB] FAIL nega8_z: got %h valid=%b, want 80", z8, got); end
        total++; if (f8 !== 4'b0110) begin bad++; $display("[TB] FAIL nega8_flags: got %b, want 0110", f8); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] zs[3];
        logic [3:0]  fs[3];
        logic        gots[3];
        int          whens[3];
        int          acs[3];
        logic [31:0] want[3];
        want[0] = 32'd7; want[1] = 32'd17; want[2] = 32'd15;
        bus.out_ready = 1'b1;
        fork
            begin
                issue(32'd3, 32'd4, ADD, 1'b0, 1'b0);       acs[0] = accept_cycle;
                issue($urandom, 32'd10, ADD, 1'b0, 1'b1);   acs[1] = accept_cycle;
                issue($urandom, 32'd2, SUB, 1'b0, 1'b1);    acs[2] = accept_cycle;
            end
            begin
                for (int i = 0; i < 3; i++) collect(6, zs[i], fs[i], gots[i], whens[i]);
            end
        join
        for (int i = 0; i < 3; i++) begin
            total++;
            if (!gots[i] || zs[i] !== want[i]) begin
                bad++; $display("[TB] FAIL acc_chain_z[%0d]: got %h valid=%b, want %h", i, zs[i], gots[i], want[i]);
            end
        end
        total++; if (acs[1] - acs[0] != 1 || acs[2] - acs[1] != 1) begin bad++; $display("[TB] FAIL acc_chain_issue_gap: got cycles %0d,%0d,%0d, want consecutive", acs[0], acs[1], acs[2]); end
        total++; if (whens[1] - whens[0] != 1 || whens[2] - whens[1] != 1) begin bad++; $display("[TB] FAIL acc_chain_result_gap: got cycles %0d,%0d,%0d, want consecutive", whens[0], whens[1], whens[2]); end
        exp_z_q.delete();
        exp_f_q.delete();
    endtask

    task automatic test_back_pressure();
        logic [31:0] z, ez, held_z;
        logic [3:0]  f, ef;
        logic        got, seen;
        int          when, base;
        base = accepted;
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) issue($urandom, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
            end
            begin
                seen = 1'b0; held_z = '0;
                for (int c = 0; c < 5; c++) begin
                    #2;
                    if (bus.out_valid) begin
                        if (!seen) begin
                            seen = 1'b1; held_z = bus.z;
                        end else begin
                            total++;
                            if (bus.z !== held_z) begin bad++; $display("[TB] FAIL stall_z_stable[%0d]: got %h, want %h", c, bus.z, held_z); end
                        end
                    end
                    @(negedge clk);
                end
                #2;
                total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_in_ready: got %b, want 0", bus.in_ready); end
                total++; if (accepted - base != 2) begin bad++; $display("[TB] FAIL stall_accepted: got %0d beats, want 2", accepted - base); end
                @(negedge clk);
                bus.out_ready = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    collect(8, z, f, got, when);
                    total++;
                    if (!got || exp_z_q.size() == 0) begin
                        bad++; $display("[TB] FAIL drain_missing[%0d]: valid=%b, want 1", i, got);
                    end else begin
                        ez = exp_z_q.pop_front();
                        ef = exp_f_q.pop_front();
                        if (z !== ez || f !== ef) begin bad++; $display("[TB] FAIL drain_order[%0d]: got %h/%b, want %h/%b", i, z, f, ez, ef); end
                    end
                end
                #1;
                total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL drain_dup: out_valid=%b, want 0", bus.out_valid); end
                @(negedge clk);
            end
        join
    endtask

    task automatic test_reset_midstream();
        logic [31:0] z;
        logic [3:0]  f;
        logic        got;
        int          when;
        bus.out_ready = 1'b0;
        issue($urandom, $urandom, ADD, 1'b0, 1'b0);
        issue($urandom, $urandom, XOR, 1'b0, 1'b0);
        #1;
        total++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL midreset_full: out_valid=%b in_ready=%b, want 1/0", bus.out_valid, bus.in_ready); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midreset_out_valid: got %b, want 0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL midreset_in_ready: got %b, want 1", bus.in_ready); end
        total++; if (bus.z !== 32'd0) begin bad++; $display("[TB] FAIL midreset_z: got %h, want 0", bus.z); end
        exp_z_q.delete();
        exp_f_q.delete();
        model_acc = '0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        issue($urandom, 32'd9, ADD, 1'b0, 1'b1);
        collect(3, z, f, got, when);
        void'(exp_z_q.pop_front()); void'(exp_f_q.pop_front());
        total++; if (!got || z !== 32'd9) begin bad++; $display("[TB] FAIL midreset_acc_cleared: got %h valid=%b, want 9", z, got); end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.inst = ADD; bus.sel = 1'b0; bus.acc = 1'b0; bus.out_ready = 1'b1;
        bus_u.in_valid = 1'b0; bus_u.a = '0; bus_u.b = '0; bus_u.inst = ADD; bus_u.sel = 1'b0; bus_u.acc = 1'b0; bus_u.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.inst = ADD; bus8.sel = 1'b0; bus8.acc = 1'b0; bus8.out_ready = 1'b1;
        model_acc = '0;
        test_reset();
        test_random_ops();
        test_flags();
        test_signedness();
        test_back_to_back();
        test_back_pressure();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end

endmodule
